// File: rtl/bounce_pkg.sv
//==============================================================================
// Module      : bounce_pkg
// Description : Shared types, palette and initial-position constants for the
//               bouncing-sprite engine.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package bounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    localparam int INIT_X_STEP = 64;
    localparam int INIT_Y_STEP = 48;

    // {R[1:0],G[1:0],B[1:0]}
    function automatic logic [5:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return 6'b11_00_11;  // magenta
            3'd1:    return 6'b00_11_00;  // green
            3'd2:    return 6'b11_00_00;  // red
            3'd3:    return 6'b00_00_11;  // blue
            3'd4:    return 6'b11_11_00;  // yellow
            3'd5:    return 6'b00_11_11;  // cyan
            3'd6:    return 6'b11_11_11;  // white
            default: return 6'b11_01_00;  // orange
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/bounce_axis.sv
//==============================================================================
// Module      : bounce_axis
// Description : One bounded axis step: move by speed, clamp at 0 / limit and
//               reverse direction on contact.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bounce_axis
    import bounce_pkg::*;
#(
    parameter int W = 11
) (
    input  logic [W-1:0] pos_i,
    input  logic         dir_i,
    input  logic [4:0]   speed_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] pos_o,
    output logic         dir_o
);

    logic [W:0] w_speed;
    logic [W:0] w_sum;
    logic [W:0] w_diff;

    assign w_speed = {{(W-4){1'b0}}, speed_i};
    assign w_sum   = {1'b0, pos_i} + w_speed;
    assign w_diff  = {1'b0, pos_i} - w_speed;

    always_comb begin
        pos_o = pos_i;
        dir_o = dir_i;
        if (dir_i == DIR_POS) begin
            if (w_sum >= {1'b0, limit_i}) begin
                pos_o = limit_i;
                dir_o = DIR_NEG;
            end else begin
                pos_o = w_sum[W-1:0];
            end
        end else begin
            // pos <= speed covers both underflow and landing exactly on 0
            if ({1'b0, pos_i} <= w_speed) begin
                pos_o = '0;
                dir_o = DIR_POS;
            end else begin
                pos_o = w_diff[W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bounce_sprite_engine.sv
//==============================================================================
// Module      : bounce_sprite_engine
// Description : Frame-rate sprite mover plus per-pixel priority renderer.
//               Optional sprite-0 collision under macro BOUNCE_COLLIDE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bounce_sprite_engine
    import bounce_pkg::*;
#(
    parameter int NUM_SPRITES = 5,
    parameter int SPRITE_SIZE = 64,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BASE_SPEED  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick_i,
    input  logic       pause_i,
    input  logic [9:0] pix_x_i,
    input  logic [9:0] pix_y_i,
    input  logic       video_active_i,
    output logic [5:0] rgb_o,
    output logic       busy_o
`ifdef BOUNCE_COLLIDE_EN
    ,
    output logic       collide_o
`endif
);

    localparam int          IDX_W   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [10:0] X_LIMIT = 11'(H_ACTIVE - SPRITE_SIZE);
    localparam logic [9:0]  Y_LIMIT = 10'(V_ACTIVE - SPRITE_SIZE);
    localparam logic [10:0] SIZE_11 = 11'(SPRITE_SIZE);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [10:0]            x_q [NUM_SPRITES];
    logic [9:0]             y_q [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] dx_q;
    logic [NUM_SPRITES-1:0] dy_q;
    logic [5:0]             rgb_q, rgb_d;

    logic       w_start;
    logic       w_commit;
    logic       w_flip;
    logic [4:0] w_speed;
    logic [10:0] w_x_step;
    logic [9:0]  w_y_step;
    logic        w_dx_step;
    logic        w_dy_step;

    assign w_start = frame_tick_i && !pause_i;
    assign w_speed = 5'(BASE_SPEED) + 5'(idx_q);
    assign busy_o  = (state_q != ST_IDLE);
    assign rgb_o   = rgb_q;

    bounce_axis #(.W(11)) u_axis_x (
        .pos_i   (x_q[idx_q]),
        .dir_i   (dx_q[idx_q]),
        .speed_i (w_speed),
        .limit_i (X_LIMIT),
        .pos_o   (w_x_step),
        .dir_o   (w_dx_step)
    );

    bounce_axis #(.W(10)) u_axis_y (
        .pos_i   (y_q[idx_q]),
        .dir_i   (dy_q[idx_q]),
        .speed_i (w_speed),
        .limit_i (Y_LIMIT),
        .pos_o   (w_y_step),
        .dir_o   (w_dy_step)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        w_commit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_UPDATE;
                    idx_d   = '0;
                end
            end
            ST_UPDATE: begin
                w_commit = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_q[i]  <= 11'(INIT_X_STEP * i);
                y_q[i]  <= 10'(INIT_Y_STEP * i);
                dx_q[i] <= DIR_POS;
                dy_q[i] <= (i % 2 == 1) ? DIR_NEG : DIR_POS;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (w_commit) begin
                x_q[idx_q]  <= w_x_step;
                y_q[idx_q]  <= w_y_step;
                dx_q[idx_q] <= w_dx_step ^ w_flip;
                dy_q[idx_q] <= w_dy_step ^ w_flip;
            end
        end
    end

`ifdef BOUNCE_COLLIDE_EN
    // Sprite i's pre-step box against sprite 0, which was already moved this frame
    logic w_overlap;
    logic collide_q, collide_d;

    assign w_overlap = (idx_q != '0)
                    && (x_q[idx_q] < x_q[0] + SIZE_11)
                    && (x_q[0] < x_q[idx_q] + SIZE_11)
                    && ({1'b0, y_q[idx_q]} < {1'b0, y_q[0]} + SIZE_11)
                    && ({1'b0, y_q[0]} < {1'b0, y_q[idx_q]} + SIZE_11);
    assign w_flip    = w_commit && w_overlap;
    assign collide_o = collide_q;

    always_comb begin
        collide_d = collide_q;
        if (state_q == ST_IDLE && w_start) begin
            collide_d = 1'b0;
        end else if (w_flip) begin
            collide_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collide_q <= 1'b0;
        end else begin
            collide_q <= collide_d;
        end
    end
`else
    assign w_flip = 1'b0;
`endif

    // Walk from the highest index down so the lowest-index hit wins
    always_comb begin
        rgb_d = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (({1'b0, pix_x_i} >= x_q[i]) && ({1'b0, pix_x_i} < x_q[i] + SIZE_11) &&
                ({1'b0, pix_y_i} >= {1'b0, y_q[i]}) &&
                ({1'b0, pix_y_i} < {1'b0, y_q[i]} + SIZE_11)) begin
                rgb_d = palette(3'(i));
            end
        end
        if (!video_active_i) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bounce_sprite_engine.sv
//==============================================================================
// Module      : tb_bounce_sprite_engine
// Description : Directed self-checking bench for bounce_sprite_engine; three
//               instances cover default, single-sprite and large-sprite builds.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bounce_sprite_engine;
    import bounce_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ft;
    logic       pause;
    logic [9:0] pix_x, pix_y;
    logic       va;
    logic [5:0] rgb0, rgb1, rgb2;
    logic       busy0, busy1, busy2;
`ifdef BOUNCE_COLLIDE_EN
    logic       col0, col1, col2;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bounce_sprite_engine dut (
        .clk(clk), .rst_n(rst_n), .frame_tick_i(ft[0]), .pause_i(pause),
        .pix_x_i(pix_x), .pix_y_i(pix_y), .video_active_i(va),
        .rgb_o(rgb0), .busy_o(busy0)
`ifdef BOUNCE_COLLIDE_EN
        , .collide_o(col0)
`endif
    );

    bounce_sprite_engine #(.NUM_SPRITES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_tick_i(ft[1]), .pause_i(pause),
        .pix_x_i(pix_x), .pix_y_i(pix_y), .video_active_i(va),
        .rgb_o(rgb1), .busy_o(busy1)
`ifdef BOUNCE_COLLIDE_EN
        , .collide_o(col1)
`endif
    );

    bounce_sprite_engine #(.NUM_SPRITES(3), .SPRITE_SIZE(128)) dut2 (
        .clk(clk), .rst_n(rst_n), .frame_tick_i(ft[2]), .pause_i(pause),
        .pix_x_i(pix_x), .pix_y_i(pix_y), .video_active_i(va),
        .rgb_o(rgb2), .busy_o(busy2)
`ifdef BOUNCE_COLLIDE_EN
        , .collide_o(col2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    task automatic pulse(input int sel);
        @(posedge clk); #1;
        ft[sel] = 1'b1;
        @(posedge clk); #1;
        ft[sel] = 1'b0;
    endtask

    task automatic wait_idle(input int sel, output int ncyc);
        ncyc = 0;
        while (busy_of(sel) && ncyc < 50) begin
            ncyc++;
            @(posedge clk); #1;
        end
        if (ncyc >= 50) chk("busy_timeout", 32'(busy_of(sel)), 0);
    endtask

    task automatic tick(input int sel, output int ncyc);
        pulse(sel);
        wait_idle(sel, ncyc);
    endtask

    task automatic show_pixel(input int px, input int py, input logic act);
        pix_x = 10'(px);
        pix_y = 10'(py);
        va    = act;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int busy_sum;
        rst_n = 1'b0;
        ft    = '0;
        pause = 1'b0;
        pix_x = '0;
        pix_y = '0;
        va    = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_busy",  32'(busy0), 0);
        chk("rst_rgb",   32'(rgb0), 0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rst_idx",   32'(dut.idx_q), 0);
        chk("rst_x1",    32'(dut.x_q[1]), 64);
        chk("rst_y1",    32'(dut.y_q[1]), 48);
        chk("rst_dy1",   32'(dut.dy_q[1]), 1);
        chk("rst_dy2",   32'(dut.dy_q[2]), 0);
        chk("rst_x4",    32'(dut.x_q[4]), 256);
        chk("rst_y4",    32'(dut.y_q[4]), 192);
`ifdef BOUNCE_COLLIDE_EN
        chk("rst_collide", 32'(col0), 0);
`endif
        rst_n = 1'b1;

        // One frame on the default build
        tick(0, n);
        chk("busy_cycles", 32'(n), 6);
        chk("f1_x0", 32'(dut.x_q[0]), 3);
        chk("f1_y0", 32'(dut.y_q[0]), 3);
        chk("f1_x1", 32'(dut.x_q[1]), 68);
        chk("f1_y1", 32'(dut.y_q[1]), 44);
        chk("f1_x3", 32'(dut.x_q[3]), 198);
        chk("f1_y3", 32'(dut.y_q[3]), 138);
        chk("f1_x4", 32'(dut.x_q[4]), 263);
        chk("f1_y4", 32'(dut.y_q[4]), 199);

        // Paused ticks do nothing
        pause = 1'b1;
        busy_sum = 0;
        for (int k = 0; k < 10; k++) begin
            tick(0, n);
            busy_sum += n;
        end
        pause = 1'b0;
        chk("pause_busy", 32'(busy_sum), 0);
        chk("pause_x0", 32'(dut.x_q[0]), 3);
        chk("pause_y0", 32'(dut.y_q[0]), 3);

        // A tick arriving mid-update is dropped
        pulse(0);
        pulse(0);
        wait_idle(0, n);
        busy_sum = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            busy_sum += 32'(busy0);
        end
        chk("dropped_tick_busy", 32'(busy_sum), 0);
        chk("dropped_tick_x0", 32'(dut.x_q[0]), 6);

        // Reset on the second UPDATE cycle
        pulse(0);
        @(posedge clk); #1;
        chk("abort_pre_x0", 32'(dut.x_q[0]), 9);
        pix_x = 10'd10;
        pix_y = 10'd10;
        va    = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("abort_busy",  32'(busy0), 0);
        chk("abort_x0",    32'(dut.x_q[0]), 0);
        chk("abort_y0",    32'(dut.y_q[0]), 0);
        chk("abort_x1",    32'(dut.x_q[1]), 64);
        chk("abort_y1",    32'(dut.y_q[1]), 48);
        chk("abort_rgb",   32'(rgb0), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_rgb", 32'(rgb0), 32'h33);

        // Renderer priority and blanking on the large-sprite build
        show_pixel(70, 50, 1'b1);
        chk("rgb_overlap", 32'(rgb2), 32'h33);
        show_pixel(70, 50, 1'b0);
        chk("rgb_blank", 32'(rgb2), 0);
        pix_x = 10'd150;
        pix_y = 10'd60;
        va    = 1'b1;
        #1;
        chk("rgb_latency", 32'(rgb2), 0);
        @(posedge clk); #1;
        chk("rgb_s1", 32'(rgb2), 32'h0C);
        show_pixel(200, 120, 1'b1);
        chk("rgb_s2", 32'(rgb2), 32'h30);
        show_pixel(300, 300, 1'b1);
        chk("rgb_none", 32'(rgb2), 0);
        va = 1'b0;

        // Single sprite bouncing off the right and bottom edges
        for (int t = 1; t <= 193; t++) begin
            tick(1, n);
            if (t == 1)   chk("n1_busy_cycles", 32'(n), 2);
            if (t == 138) chk("n1_y_t138", 32'(dut1.y_q[0]), 414);
            if (t == 139) begin
                chk("n1_y_t139", 32'(dut1.y_q[0]), 416);
                chk("n1_dy_t139", 32'(dut1.dy_q[0]), 1);
            end
            if (t == 192) begin
                chk("n1_x_t192", 32'(dut1.x_q[0]), 576);
                chk("n1_dx_t192", 32'(dut1.dx_q[0]), 1);
                chk("n1_y_t192", 32'(dut1.y_q[0]), 257);
            end
            if (t == 193) chk("n1_x_t193", 32'(dut1.x_q[0]), 573);
        end

`ifdef BOUNCE_COLLIDE_EN
        // Sprites 1 and 2 both start inside sprite 0's box on the large build
        tick(2, n);
        chk("col_flag", 32'(col2), 1);
        chk("col_x2",  32'(dut2.x_q[2]), 133);
        chk("col_y2",  32'(dut2.y_q[2]), 101);
        chk("col_dx2", 32'(dut2.dx_q[2]), 1);
        chk("col_dy2", 32'(dut2.dy_q[2]), 1);
        chk("col_dx1", 32'(dut2.dx_q[1]), 1);
        chk("col_dy1", 32'(dut2.dy_q[1]), 0);
        pulse(2);
        chk("col_clear", 32'(col2), 0);
        wait_idle(2, n);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bounce_sprite_engine.md
BOUNCE_SPRITE_ENGINE -- requirements
Module: bounce_sprite_engine

Interface
REQ-001 Parameter NUM_SPRITES, default 5, number of sprites, legal 1..8.
REQ-002 Parameter SPRITE_SIZE, default 64, sprite edge in pixels, legal 8..128.
REQ-003 Parameter H_ACTIVE, default 640, visible width in pixels.
REQ-004 Parameter V_ACTIVE, default 480, visible height in pixels.
REQ-005 Parameter BASE_SPEED, default 3, pixels/frame for sprite 0; legal 1..15.
REQ-006 clk  in  1  single clock; every flop SHALL be clocked on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 frame_tick  in  1  one-cycle pulse at vblank start.
REQ-009 pause  in  1  when high, frame_tick SHALL NOT start an update.
REQ-010 pix_x / pix_y  in  10 each  current beam position.
REQ-011 video_active  in  1  beam is in the visible area.
REQ-012 rgb  out  6  {R[1:0],G[1:0],B[1:0]}, registered.
REQ-013 busy  out  1  high while an update is in progress.
REQ-014 collide  out  1  sprite-overlap flag; present only under the macro.

Function
REQ-015 Per sprite i state: x (11b), y (10b), dir_x, dir_y, all unsigned.
REQ-016 Speed of sprite i SHALL be BASE_SPEED+i on both axes.
REQ-017 FSM states: IDLE, UPDATE, DONE.
- IDLE->UPDATE on frame_tick && !pause.
- UPDATE processes one sprite per cycle, index 0..NUM_SPRITES-1.
- UPDATE->DONE after the last index.
- DONE->IDLE after one cycle.
REQ-018 busy SHALL be high in UPDATE and DONE; update latency is NUM_SPRITES+1 cycles.
REQ-019 frame_tick arriving while busy SHALL be ignored; it SHALL NOT be queued.
REQ-020 Axis update, x: next = x ± speed.
- If moving + and next >= H_ACTIVE-SPRITE_SIZE: x = H_ACTIVE-SPRITE_SIZE, dir_x flips.
- If moving - and x < speed (underflow) or next == 0: x = 0, dir_x flips.
REQ-021 The y axis SHALL follow REQ-020 with V_ACTIVE.
REQ-022 Positions SHALL never leave [0, ACTIVE-SPRITE_SIZE].
REQ-023 Pixel hit for sprite i: x <= pix_x < x+SIZE and y <= pix_y < y+SIZE.
REQ-024 rgb SHALL be palette[k] for the lowest-index hit sprite k, else 0.
REQ-025 rgb SHALL be 0 when video_active is low.
REQ-026 rgb latency SHALL be 1 cycle from pix_x/pix_y.
REQ-027 The renderer SHALL use committed positions; positions update in place during UPDATE, so tearing during vblank is acceptable.

Reset
REQ-028 While rst_n is low at a clock edge, every sprite SHALL load its initial state.
- x = 64*i, y = 48*i.
- dir_x = +.
- dir_y = + for even i, - for odd i.
REQ-029 Reset values: FSM = IDLE, index = 0, busy = 0, rgb = 0, collide = 0.
REQ-030 Reset asserted mid-UPDATE SHALL abort the update with no partial commit after the reset edge.

Configuration
REQ-031 Macro BOUNCE_COLLIDE_EN.
- Defined: during UPDATE, each sprite's box SHALL be compared with sprite 0 (i>0). On overlap, both of sprite i's dir bits SHALL flip and collide SHALL be set.
- collide SHALL clear at the next IDLE->UPDATE transition.
REQ-032 Without BOUNCE_COLLIDE_EN: the collide port SHALL be absent, no comparators SHALL be built, and sprites SHALL pass through each other.

Structure
REQ-033 Package bounce_pkg SHALL hold:
- the FSM state typedef;
- the 8-entry 6-bit palette (magenta, green, red, blue, yellow, cyan, white, orange);
- initial-position constants.
REQ-034 Sub-module bounce_axis SHALL perform one axis step (pos, dir, speed, limit -> pos, dir); it is instantiated twice.

Verification
REQ-035 Reset, then one frame_tick: sprite0 = (3,3); sprite1 = (68,44); busy high for 6 cycles.
REQ-036 NUM_SPRITES=1, 192 ticks: x=576 with dir_x flipped; tick 193 gives x=573. Tick 139 clamps y at 416.
REQ-037 pause=1 for 10 ticks: positions unchanged. frame_tick during busy: exactly one update occurs.
REQ-038 Sprites 0 and 1 overlapping at pixel (70,50): rgb = palette[0] one cycle later; with video_active=0, rgb = 0.
REQ-039 rst_n low on UPDATE cycle 2: next cycle state is IDLE, all positions at initial values, rgb = 0.
REQ-040 With BOUNCE_COLLIDE_EN, forced overlap of sprites 0 and 2: collide=1 and sprite 2's dirs inverted; collide clears on the next tick.
